// File: rtl/muldiv_pkg.sv
// Shared definitions for the M-extension sequencer: funct3 codes, FSM encoding,
// unit selection and the multiplier operand sign policy.
package muldiv_pkg;

   localparam logic [2:0] F3_MUL    = 3'd0;
   localparam logic [2:0] F3_MULH   = 3'd1;
   localparam logic [2:0] F3_MULHSU = 3'd2;
   localparam logic [2:0] F3_MULHU  = 3'd3;
   localparam logic [2:0] F3_DIV    = 3'd4;
   localparam logic [2:0] F3_DIVU   = 3'd5;
   localparam logic [2:0] F3_REM    = 3'd6;
   localparam logic [2:0] F3_REMU   = 3'd7;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LAUNCH = 3'd1,
      ST_WAIT   = 3'd2,
      ST_FIXUP  = 3'd3,
      ST_RESP   = 3'd4
   } state_t;

   typedef enum logic [1:0] {
      UNIT_MUL  = 2'd0,
      UNIT_DIV  = 2'd1,
      UNIT_DIVU = 2'd2
   } unit_t;

   // Odd funct3 codes in the divide half are the unsigned variants.
   function automatic unit_t unit_of(input logic [2:0] f3);
      if (!f3[2])
         return UNIT_MUL;
      else if (f3[0])
         return UNIT_DIVU;
      else
         return UNIT_DIV;
   endfunction

   // Returns {a_signed, b_signed}. MUL low word is sign-independent, so it runs raw.
   function automatic logic [1:0] sign_policy(input logic [2:0] f3);
      case (f3)
         F3_MULH:   return 2'b11;
         F3_MULHSU: return 2'b10;
         default:   return 2'b00;
      endcase
   endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Combinational sign handling around the unsigned 32x32->64 multiplier:
// magnitude operand prep on the way in, conditional 64-bit negate on the way out.
module muldiv_sign_fix
   import muldiv_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [63:0] prod,
   input  logic        neg_in,
   output logic [31:0] op_a,
   output logic [31:0] op_b,
   output logic        neg,
   output logic [63:0] prod_fixed
);

   logic [1:0] policy;
   logic       a_neg;
   logic       b_neg;

   assign policy = sign_policy(funct3);
   assign a_neg  = policy[1] & a[31];
   assign b_neg  = policy[0] & b[31];

   // 32'h8000_0000 maps to itself, which is its correct unsigned magnitude.
   assign op_a = a_neg ? (~a + 32'd1) : a;
   assign op_b = b_neg ? (~b + 32'd1) : b;
   assign neg  = a_neg ^ b_neg;

   assign prod_fixed = neg_in ? (~prod + 64'd1) : prod;

endmodule

// File: rtl/muldiv_sequencer.sv
// Sequences the iterative mul/div/divu units for one M-extension op at a time.
// Optional corner-case shortcut for divides is enabled by MULDIV_FASTPATH_EN.
module muldiv_sequencer
   import muldiv_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 64
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_a,
   input  logic [31:0] req_b,
   output logic [31:0] unit_a,
   output logic [31:0] unit_b,
   output logic        mul_rst,
   output logic        div_rst,
   output logic        divu_rst,
   input  logic [31:0] mul_o_high,
   input  logic [31:0] mul_o_low,
   input  logic        mul_finish,
   input  logic [31:0] div_q,
   input  logic [31:0] div_r,
   input  logic        div_finish,
   input  logic [31:0] divu_q,
   input  logic [31:0] divu_r,
   input  logic        divu_finish,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic        rsp_err,
   output logic        busy,
   output logic [2:0]  state_dbg
);

   // Handshakes: a transfer happens on a rising edge where valid && ready are both
   // high; the producer holds valid and its payload stable until that edge, and
   // ready never depends combinationally on valid.

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

   state_t          state;
   logic [2:0]      f3_r;
   unit_t           unit_r;
   logic            neg_r;
   logic            fast_r;
   logic [CW-1:0]   wait_cnt;

   logic [31:0]     op_a;
   logic [31:0]     op_b;
   logic            neg_w;
   logic [63:0]     prod_fixed;
   logic            unit_finish;
   logic [31:0]     result;
   logic            fast_hit;
   logic [31:0]     fast_data;
   unit_t           req_unit;

   assign req_unit  = unit_of(req_funct3);
   assign busy      = (state != ST_IDLE);
   assign state_dbg = state;

   // Operand prep reads the live request; product fixup uses the sign latched at accept.
   muldiv_sign_fix u_sign_fix (
      .funct3     (req_funct3),
      .a          (req_a),
      .b          (req_b),
      .prod       ({mul_o_high, mul_o_low}),
      .neg_in     (neg_r),
      .op_a       (op_a),
      .op_b       (op_b),
      .neg        (neg_w),
      .prod_fixed (prod_fixed)
   );

`ifdef MULDIV_FASTPATH_EN
   always_comb begin
      fast_hit = 1'b0;
      if (req_funct3[2]) begin
         if (req_b == 32'd0)
            fast_hit = 1'b1;
         else if (!req_funct3[0] && req_a == 32'h8000_0000 && req_b == 32'hFFFF_FFFF)
            fast_hit = 1'b1;
      end
   end

   // Divide operands were latched raw, so unit_a/unit_b are the original dividend/divisor.
   always_comb begin
      fast_data = 32'd0;
      if (unit_b == 32'd0)
         fast_data = (f3_r == F3_DIV || f3_r == F3_DIVU) ? 32'hFFFF_FFFF : unit_a;
      else if (f3_r == F3_DIV)
         fast_data = unit_a;
   end
`else
   assign fast_hit  = 1'b0;
   assign fast_data = 32'd0;
`endif

   always_comb begin
      unit_finish = 1'b0;
      case (unit_r)
         UNIT_MUL:  unit_finish = mul_finish;
         UNIT_DIV:  unit_finish = div_finish;
         UNIT_DIVU: unit_finish = divu_finish;
         default:   unit_finish = 1'b0;
      endcase
   end

   always_comb begin
      result = 32'd0;
      case (f3_r)
         F3_MUL:    result = prod_fixed[31:0];
         F3_MULH:   result = prod_fixed[63:32];
         F3_MULHSU: result = prod_fixed[63:32];
         F3_MULHU:  result = prod_fixed[63:32];
         F3_DIV:    result = div_q;
         F3_REM:    result = div_r;
         F3_DIVU:   result = divu_q;
         F3_REMU:   result = divu_r;
         default:   result = 32'd0;
      endcase
      if (fast_r)
         result = fast_data;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         req_ready <= 1'b0;
         mul_rst   <= 1'b1;
         div_rst   <= 1'b1;
         divu_rst  <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_data  <= 32'd0;
         rsp_err   <= 1'b0;
         unit_a    <= 32'd0;
         unit_b    <= 32'd0;
         f3_r      <= F3_MUL;
         unit_r    <= UNIT_MUL;
         neg_r     <= 1'b0;
         fast_r    <= 1'b0;
         wait_cnt  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               mul_rst  <= 1'b0;
               div_rst  <= 1'b0;
               divu_rst <= 1'b0;
               if (req_valid && req_ready) begin
                  req_ready <= 1'b0;
                  f3_r      <= req_funct3;
                  unit_r    <= req_unit;
                  unit_a    <= op_a;
                  unit_b    <= op_b;
                  neg_r     <= neg_w;
                  fast_r    <= fast_hit;
                  rsp_err   <= 1'b0;
                  if (fast_hit) begin
                     state <= ST_FIXUP;
                  end else begin
                     state    <= ST_LAUNCH;
                     mul_rst  <= (req_unit == UNIT_MUL);
                     div_rst  <= (req_unit == UNIT_DIV);
                     divu_rst <= (req_unit == UNIT_DIVU);
                  end
               end else begin
                  req_ready <= 1'b1;
               end
            end
            ST_LAUNCH: begin
               mul_rst  <= 1'b0;
               div_rst  <= 1'b0;
               divu_rst <= 1'b0;
               wait_cnt <= '0;
               state    <= ST_WAIT;
            end
            ST_WAIT: begin
               // The first WAIT cycle may still see finish from the previous op.
               if (unit_finish && wait_cnt != '0) begin
                  state <= ST_FIXUP;
               end else if (wait_cnt == CNT_LAST) begin
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b1;
                  rsp_data  <= 32'd0;
                  state     <= ST_RESP;
               end else begin
                  wait_cnt <= wait_cnt + CW'(1);
               end
            end
            ST_FIXUP: begin
               rsp_data  <= result;
               rsp_valid <= 1'b1;
               state     <= ST_RESP;
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  rsp_err   <= 1'b0;
                  req_ready <= 1'b1;
                  state     <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer with behavioural multiplier/divider unit models;
// corner-case expectations follow MULDIV_FASTPATH_EN when it is defined.
module tb_muldiv_sequencer;
   import muldiv_pkg::*;

   localparam int TIMEOUT  = 16;
   localparam int UNIT_LAT = 8;
   localparam int NL       = UNIT_LAT + 4;
   localparam int BUDGET   = 200;

`ifdef MULDIV_FASTPATH_EN
   localparam int         CL      = 2;
   localparam logic [2:0] CR_DIV  = 3'b000;
   localparam logic [2:0] CR_DIVU = 3'b000;
`else
   localparam int         CL      = NL;
   localparam logic [2:0] CR_DIV  = 3'b010;
   localparam logic [2:0] CR_DIVU = 3'b001;
`endif

   logic        clk;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_funct3;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic [31:0] unit_a;
   logic [31:0] unit_b;
   logic        mul_rst;
   logic        div_rst;
   logic        divu_rst;
   logic [31:0] mul_o_high;
   logic [31:0] mul_o_low;
   logic        mul_finish;
   logic [31:0] div_q;
   logic [31:0] div_r;
   logic        div_finish;
   logic [31:0] divu_q;
   logic [31:0] divu_r;
   logic        divu_finish;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;
   logic        rsp_err;
   logic        busy;
   logic [2:0]  state_dbg;

   int          n_checks = 0;
   int          n_pass   = 0;
   logic [31:0] exp_q[$];
   logic        hang;

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   muldiv_sequencer #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_funct3  (req_funct3),
      .req_a       (req_a),
      .req_b       (req_b),
      .unit_a      (unit_a),
      .unit_b      (unit_b),
      .mul_rst     (mul_rst),
      .div_rst     (div_rst),
      .divu_rst    (divu_rst),
      .mul_o_high  (mul_o_high),
      .mul_o_low   (mul_o_low),
      .mul_finish  (mul_finish),
      .div_q       (div_q),
      .div_r       (div_r),
      .div_finish  (div_finish),
      .divu_q      (divu_q),
      .divu_r      (divu_r),
      .divu_finish (divu_finish),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_data    (rsp_data),
      .rsp_err     (rsp_err),
      .busy        (busy),
      .state_dbg   (state_dbg)
   );

   // ---------------- unit models ----------------
   function automatic logic [63:0] sdiv(input logic [31:0] a, input logic [31:0] b);
      if (b == 32'd0) return {32'hFFFF_FFFF, a};
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {a, 32'd0};
      return {32'($signed(a) / $signed(b)), 32'($signed(a) % $signed(b))};
   endfunction

   function automatic logic [63:0] udiv(input logic [31:0] a, input logic [31:0] b);
      if (b == 32'd0) return {32'hFFFF_FFFF, a};
      return {a / b, a % b};
   endfunction

   logic [7:0] mul_cnt, div_cnt, divu_cnt;
   logic       mul_done, div_done, divu_done;

   always_ff @(posedge clk) begin
      if (mul_rst) begin
         mul_cnt  <= 8'd0;
         mul_done <= 1'b0;
      end else if (!mul_done) begin
         mul_cnt <= mul_cnt + 8'd1;
         if (mul_cnt == 8'(UNIT_LAT - 1)) begin
            mul_done <= 1'b1;
            {mul_o_high, mul_o_low} <= {32'd0, unit_a} * {32'd0, unit_b};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (div_rst) begin
         div_cnt  <= 8'd0;
         div_done <= 1'b0;
      end else if (!div_done) begin
         div_cnt <= div_cnt + 8'd1;
         if (div_cnt == 8'(UNIT_LAT - 1)) begin
            div_done       <= 1'b1;
            {div_q, div_r} <= sdiv(unit_a, unit_b);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (divu_rst) begin
         divu_cnt  <= 8'd0;
         divu_done <= 1'b0;
      end else if (!divu_done) begin
         divu_cnt <= divu_cnt + 8'd1;
         if (divu_cnt == 8'(UNIT_LAT - 1)) begin
            divu_done        <= 1'b1;
            {divu_q, divu_r} <= udiv(unit_a, unit_b);
         end
      end
   end

   assign mul_finish  = mul_done  & ~hang;
   assign div_finish  = div_done  & ~hang;
   assign divu_finish = divu_done & ~hang;

   // ---------------- check / driver tasks ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic do_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_data, input int exp_lat,
                        input logic [2:0] exp_rst, input logic exp_err, input int hold);
      int          lat;
      int          waited;
      logic [2:0]  rst_seen;
      logic [31:0] exp;
      exp_q.push_back(exp_data);
      @(negedge clk);
      waited = 0;
      while (!req_ready && waited < BUDGET) begin
         @(negedge clk);
         waited++;
      end
      check({tag, " req_ready"}, 32'(req_ready), 32'd1);
      req_valid  = 1'b1;
      req_funct3 = f3;
      req_a      = a;
      req_b      = b;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      lat       = 1;
      rst_seen  = {mul_rst, div_rst, divu_rst};
      check({tag, " busy"}, 32'(busy), 32'd1);
      while (!rsp_valid && lat < BUDGET) begin
         @(posedge clk);
         #1;
         lat++;
         rst_seen |= {mul_rst, div_rst, divu_rst};
      end
      exp = exp_q.pop_front();
      check({tag, " latency"}, 32'(lat), 32'(exp_lat));
      check({tag, " unit_rst"}, 32'(rst_seen), 32'(exp_rst));
      check({tag, " data"}, rsp_data, exp);
      check({tag, " err"}, 32'(rsp_err), 32'(exp_err));
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check({tag, " hold valid"}, 32'(rsp_valid), 32'd1);
         check({tag, " hold data"}, rsp_data, exp);
         check({tag, " hold req_ready"}, 32'(req_ready), 32'd0);
      end
      @(negedge clk);
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      check({tag, " valid drop"}, 32'(rsp_valid), 32'd0);
      check({tag, " req_ready back"}, 32'(req_ready), 32'd1);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      reset      = 1'b1;
      req_valid  = 1'b0;
      req_funct3 = 3'd0;
      req_a      = 32'd0;
      req_b      = 32'd0;
      rsp_ready  = 1'b0;
      hang       = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst req_ready", 32'(req_ready), 32'd0);
      check("rst unit_rst", 32'({mul_rst, div_rst, divu_rst}), 32'b111);
      check("rst rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst rsp_data", rsp_data, 32'd0);
      check("rst rsp_err", 32'(rsp_err), 32'd0);
      check("rst busy", 32'(busy), 32'd0);
      check("rst unit_a", unit_a, 32'd0);
      check("rst unit_b", unit_b, 32'd0);
      check("rst state", 32'(state_dbg), 32'(ST_IDLE));
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      check("post-rst req_ready", 32'(req_ready), 32'd1);
      check("post-rst unit_rst", 32'({mul_rst, div_rst, divu_rst}), 32'b000);

      // multiplier sign handling
      do_op("mulh -3*5",       F3_MULH,   32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, NL, 3'b100, 1'b0, 0);
      do_op("mul 2^16*2^16",   F3_MUL,    32'h0001_0000, 32'h0001_0000, 32'h0000_0000, NL, 3'b100, 1'b0, 0);
      do_op("mulhu 2^16*2^16", F3_MULHU,  32'h0001_0000, 32'h0001_0000, 32'h0000_0001, NL, 3'b100, 1'b0, 0);
      do_op("mul -3*5",        F3_MUL,    32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFF1, NL, 3'b100, 1'b0, 0);
      do_op("mulhsu -1*2^31",  F3_MULHSU, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, NL, 3'b100, 1'b0, 0);
      do_op("mulh min*min",    F3_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, NL, 3'b100, 1'b0, 0);

      // dividers, normal operands
      do_op("div -7/2",   F3_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, NL, 3'b010, 1'b0, 0);
      do_op("rem -7/2",   F3_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, NL, 3'b010, 1'b0, 0);
      do_op("divu 100/7", F3_DIVU, 32'd100,       32'd7, 32'd14,        NL, 3'b001, 1'b0, 0);
      do_op("remu 100/7", F3_REMU, 32'd100,       32'd7, 32'd2,         NL, 3'b001, 1'b0, 0);

      // divider corner cases
      do_op("div 7/0",      F3_DIV,  32'd7,         32'd0,         32'hFFFF_FFFF, CL, CR_DIV,  1'b0, 0);
      do_op("remu 9/0",     F3_REMU, 32'd9,         32'd0,         32'd9,         CL, CR_DIVU, 1'b0, 0);
      do_op("rem min/-1",   F3_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         CL, CR_DIV,  1'b0, 0);
      do_op("div min/-1",   F3_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, CL, CR_DIV,  1'b0, 0);

      // unit never finishes
      hang = 1'b1;
      do_op("timeout", F3_MUL, 32'd5, 32'd6, 32'd0, TIMEOUT + 2, 3'b100, 1'b1, 0);
      hang = 1'b0;

      // reset in the middle of WAIT
      @(negedge clk);
      req_valid  = 1'b1;
      req_funct3 = F3_DIVU;
      req_a      = 32'd100;
      req_b      = 32'd7;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      check("midrst unit_rst", 32'({mul_rst, div_rst, divu_rst}), 32'b111);
      check("midrst rsp_valid", 32'(rsp_valid), 32'd0);
      check("midrst busy", 32'(busy), 32'd0);
      check("midrst req_ready", 32'(req_ready), 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      check("midrst req_ready back", 32'(req_ready), 32'd1);
      check("midrst no rsp", 32'(rsp_valid), 32'd0);
      do_op("divu after rst", F3_DIVU, 32'd100, 32'd7, 32'd14, NL, 3'b001, 1'b0, 0);

      // consumer backpressure
      do_op("mulhu backpressure", F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, NL, 3'b100, 1'b0, 5);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
